pixel_stream_writer: RTL
========================

PIXEL_STREAM_WRITER -- requirements
Module: pixel_stream_writer

Interface
REQ-001 SHALL have parameter CHAINED, default 2, number of chained 64-column panels; MAX_LED = 64*CHAINED.
REQ-002 SHALL have parameter INPUT_DEPTH, default 6, bits kept per color channel.
REQ-003 ctrl_clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 s_data  input  8  inbound byte stream.
REQ-006 s_valid  input  1  s_data valid.
REQ-007 s_last  input  1  marks the final byte of a packet; qualified by s_valid.
REQ-008 s_ready  output  1  byte accepted when s_valid && s_ready.
REQ-009 ctrl_en  output  1  one-cycle memory write strobe.
REQ-010 ctrl_wr  output  4  channel write mask; 4'b0111 when ctrl_en is high, else 0.
REQ-011 ctrl_addr  output  16  write address {row[5:0], col[5+log2(CHAINED):0]}, zero-extended.
REQ-012 ctrl_wdat  output  24  {R,G,B} fields at bits [16+:INPUT_DEPTH], [8+:INPUT_DEPTH], [0+:INPUT_DEPTH]; all other bits 0.
REQ-013 line_done  output  1  one-cycle pulse when a packet ends without error.
REQ-014 pkt_err  output  1  one-cycle pulse when a packet is dropped.

Function
REQ-015 Packet format SHALL be: row byte, start-column byte, then zero or more R,G,B byte triplets; s_last on the final byte.
REQ-016 States SHALL be IDLE, COL, RED, GRN, BLU, WRITE, DROP.
REQ-017 IDLE: on accept, if s_data[7:6]!=0 -> DROP, else latch row=s_data[5:0] -> COL.
REQ-018 COL: on accept, if s_data >= MAX_LED -> DROP, else latch col -> RED.
REQ-019 RED/GRN: on accept, latch s_data[7:8-INPUT_DEPTH] (MSB truncation, no rounding) into the channel register -> next state.
REQ-020 BLU: on accept, latch blue -> WRITE.
REQ-021 WRITE: s_ready=0; ctrl_en=1, ctrl_wr=4'b0111, ctrl_addr={row,col}, ctrl_wdat as REQ-012 for exactly this one cycle; col increments; next state RED, or IDLE if the BLU byte carried s_last.
REQ-022 s_ready SHALL be 1 in every state except WRITE and except while reset is asserted.
REQ-023 Outputs SHALL be registered: write appears the cycle after the blue byte is accepted (latency 1).
REQ-024 A packet whose blue byte is accepted with s_last SHALL pulse line_done in the WRITE cycle.
REQ-025 s_last accepted in COL or BLU SHALL be legal end; s_last in COL (header-only packet) -> IDLE with line_done and no write.
REQ-026 s_last accepted in IDLE, RED, or GRN (partial header or partial pixel) SHALL discard the partial pixel, pulse pkt_err, -> IDLE; no write.
REQ-027 Column overflow: if col reaches MAX_LED after a write and the packet has not ended, next state SHALL be DROP; col SHALL NOT wrap.
REQ-028 DROP: accept and discard bytes; on accepted s_last pulse pkt_err -> IDLE.
REQ-029 On entry to DROP from IDLE or COL due to a header error, if that byte also carries s_last, SHALL pulse pkt_err and go directly to IDLE.
REQ-030 Writes completed before an overflow or error SHALL remain valid; they SHALL NOT be undone.
REQ-031 line_done and pkt_err SHALL never pulse in the same cycle.

Reset
REQ-032 Asynchronous reset SHALL force state IDLE, ctrl_en=0, ctrl_wr=0, ctrl_addr=0, ctrl_wdat=0, line_done=0, pkt_err=0, s_ready=0, row=col=0.
REQ-033 Reset mid-packet SHALL abandon the packet with no write and no pulse; the first byte after release SHALL be parsed as a row byte.
REQ-034 s_ready SHALL go 1 on the first clock edge after reset deasserts.

Verification
REQ-035 Bytes 05,10,FF,80,04 (last on 04) -> one write: addr=0x0290, wdat=0x3F2001, ctrl_wr=0111; line_done pulse; no pkt_err.
REQ-036 Row 00, col 7E, 3 pixels, CHAINED=2 -> writes at cols 7E,7F; third pixel dropped; pkt_err on last byte; no line_done.
REQ-037 Bytes 40,00,.. (last) -> no write, pkt_err once; bytes 01,80 (col>=128) -> DROP, pkt_err.
REQ-038 Bytes 03,00,AA,BB (last on BB) -> no write, pkt_err; next packet parses normally.
REQ-039 Hold s_valid=1 continuously over 4 pixels -> s_ready low exactly one cycle per pixel; 4 writes at consecutive cols.
REQ-040 Assert reset between GRN and BLU bytes -> all outputs 0 immediately (asynchronous); no write; the next packet is correct.

Source files
------------

// File: rtl/pixel_stream_writer.sv
// Byte-stream to LED frame-buffer writer: parses row/column headers followed by
// RGB triplets and issues one registered memory write per completed pixel.
module pixel_stream_writer #(
   parameter int unsigned CHAINED     = 2,
   parameter int unsigned INPUT_DEPTH = 6
) (
   input  logic        ctrl_clk,
   input  logic        reset,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   output logic        ctrl_en,
   output logic [3:0]  ctrl_wr,
   output logic [15:0] ctrl_addr,
   output logic [23:0] ctrl_wdat,
   output logic        line_done,
   output logic        pkt_err
);

   localparam int unsigned MaxLed = 64 * CHAINED;
   localparam int unsigned ColW   = 6 + $clog2(CHAINED);
   // One spare bit so the column can sit at MaxLed after the final write without wrapping.
   localparam logic [ColW:0] ColEnd = (ColW + 1)'(MaxLed);

   typedef enum logic [2:0] {
      StIdle,
      StCol,
      StRed,
      StGrn,
      StBlu,
      StWrite,
      StDrop
   } state_e;

   state_e                 state_q, state_d;
   logic [5:0]             row_q, row_d;
   logic [ColW:0]          col_q, col_d;
   logic [INPUT_DEPTH-1:0] red_q, red_d;
   logic [INPUT_DEPTH-1:0] grn_q, grn_d;
   logic                   last_q, last_d;
   logic                   ready_q, ready_d;
   logic                   en_q, en_d;
   logic [3:0]             wr_q, wr_d;
   logic [15:0]            addr_q, addr_d;
   logic [23:0]            wdat_q, wdat_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic                   accept;

   assign accept    = s_valid && ready_q;
   assign s_ready   = ready_q;
   assign ctrl_en   = en_q;
   assign ctrl_wr   = wr_q;
   assign ctrl_addr = addr_q;
   assign ctrl_wdat = wdat_q;
   assign line_done = done_q;
   assign pkt_err   = err_q;

   // Next-state, datapath latching and registered-output staging.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      red_d   = red_q;
      grn_d   = grn_q;
      last_d  = last_q;
      en_d    = 1'b0;
      wr_d    = 4'b0000;
      addr_d  = 16'h0000;
      wdat_d  = 24'h000000;
      done_d  = 1'b0;
      err_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (s_data[7:6] != 2'b00) begin
                  if (s_last) begin
                     err_d = 1'b1;
                  end else begin
                     state_d = StDrop;
                  end
               end else if (s_last) begin
                  // Row byte alone is a truncated header.
                  err_d = 1'b1;
               end else begin
                  row_d   = s_data[5:0];
                  state_d = StCol;
               end
            end
         end
         StCol: begin
            if (accept) begin
               if (32'(s_data) >= MaxLed) begin
                  if (s_last) begin
                     err_d   = 1'b1;
                     state_d = StIdle;
                  end else begin
                     state_d = StDrop;
                  end
               end else if (s_last) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  col_d   = (ColW + 1)'(s_data);
                  state_d = StRed;
               end
            end
         end
         StRed: begin
            if (accept) begin
               if (s_last) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  red_d   = s_data[7 -: INPUT_DEPTH];
                  state_d = StGrn;
               end
            end
         end
         StGrn: begin
            if (accept) begin
               if (s_last) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  grn_d   = s_data[7 -: INPUT_DEPTH];
                  state_d = StBlu;
               end
            end
         end
         StBlu: begin
            if (accept) begin
               en_d                       = 1'b1;
               wr_d                       = 4'b0111;
               addr_d                     = 16'({row_q, col_q[ColW-1:0]});
               wdat_d[16 +: INPUT_DEPTH]  = red_q;
               wdat_d[8 +: INPUT_DEPTH]   = grn_q;
               wdat_d[0 +: INPUT_DEPTH]   = s_data[7 -: INPUT_DEPTH];
               done_d                     = s_last;
               last_d                     = s_last;
               state_d                    = StWrite;
            end
         end
         StWrite: begin
            col_d = col_q + 1'b1;
            if (last_q) begin
               state_d = StIdle;
            end else if (col_q + 1'b1 == ColEnd) begin
               state_d = StDrop;
            end else begin
               state_d = StRed;
            end
         end
         StDrop: begin
            if (accept && s_last) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Stall input only during the write cycle.
      ready_d = (state_d != StWrite);
   end

   // State and output registers with asynchronous active-high reset.
   always_ff @(posedge ctrl_clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         row_q   <= '0;
         col_q   <= '0;
         red_q   <= '0;
         grn_q   <= '0;
         last_q  <= 1'b0;
         ready_q <= 1'b0;
         en_q    <= 1'b0;
         wr_q    <= 4'b0000;
         addr_q  <= 16'h0000;
         wdat_q  <= 24'h000000;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         red_q   <= red_d;
         grn_q   <= grn_d;
         last_q  <= last_d;
         ready_q <= ready_d;
         en_q    <= en_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

endmodule
